beat_sequencer: RTL

- Parametrised successor to the single-rate beat counter.
- Steps a pattern-memory address `beat_addr` through the inclusive range [start_addr, end_addr] at a programmable tempo.
- Tempo comes from a fractional phase accumulator in the main clock domain; no derived clock.
- Adds loop, one-shot and ping-pong modes, run/pause, synchronous restart, a beat strobe, a loop counter and a done flag. Sits between the tempo control and the note/pattern ROM feeding the voice generators.

---
 rtl/beat_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/beat_sequencer.sv
// Steps a pattern address through [start_addr, end_addr] at a tempo set by a
// fractional phase accumulator. Supports loop, one-shot and ping-pong modes.
module beat_sequencer #(
  parameter int ADDR_WIDTH  = 10,
  parameter int PHASE_WIDTH = 32,
  parameter int LOOP_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   restart,
  input  logic [1:0]             mode,
  input  logic [ADDR_WIDTH-1:0]  start_addr,
  input  logic [ADDR_WIDTH-1:0]  end_addr,
  input  logic [PHASE_WIDTH-1:0] phase_inc,
  output logic [ADDR_WIDTH-1:0]  beat_addr,
  output logic                   beat_tick,
  output logic [LOOP_WIDTH-1:0]  loop_count,
  output logic                   done
);

  localparam logic [1:0] MODE_ONESHOT  = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [LOOP_WIDTH-1:0] LOOP_ONE = LOOP_WIDTH'(1);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic [PHASE_WIDTH-1:0] acc_q, acc_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  dir_t                   dir_q, dir_d;
  logic                   tick_q, tick_d;
  logic [LOOP_WIDTH-1:0]  loop_q, loop_d;
  logic                   done_q, done_d;
  logic [PHASE_WIDTH:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, phase_inc};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      addr_q <= '0;
      dir_q  <= DIR_UP;
      tick_q <= 1'b0;
      loop_q <= '0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      addr_q <= addr_d;
      dir_q  <= dir_d;
      tick_q <= tick_d;
      loop_q <= loop_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    acc_d  = acc_q;
    addr_d = addr_q;
    dir_d  = dir_q;
    tick_d = 1'b0;
    loop_d = loop_q;
    done_d = done_q;

    if (restart) begin
      acc_d  = '0;
      addr_d = start_addr;
      dir_d  = DIR_UP;
      loop_d = '0;
      done_d = 1'b0;
      tick_d = 1'b1;
    end else if (run && !done_q) begin
      acc_d = sum[PHASE_WIDTH-1:0];
      if (sum[PHASE_WIDTH]) begin
        // Degenerate range collapses to start_addr; checked before the
        // out-of-range rule, which would otherwise swallow it.
        if (end_addr < start_addr) begin
          addr_d = start_addr;
          dir_d  = DIR_UP;
          tick_d = 1'b1;
          if (mode == MODE_ONESHOT) done_d = 1'b1;
          else                      loop_d = loop_q + LOOP_ONE;
        end else if (addr_q < start_addr || addr_q > end_addr) begin
          addr_d = start_addr;
          dir_d  = DIR_UP;
          tick_d = 1'b1;
        end else if (mode == MODE_ONESHOT) begin
          dir_d = DIR_UP;
          if (addr_q == end_addr) begin
            done_d = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_ONE;
            tick_d = 1'b1;
          end
        end else if (mode == MODE_PINGPONG) begin
          tick_d = 1'b1;
          if (dir_q == DIR_UP) begin
            if (addr_q == end_addr) begin
              if (start_addr == end_addr) begin
                loop_d = loop_q + LOOP_ONE;
              end else begin
                addr_d = end_addr - ADDR_ONE;
                dir_d  = DIR_DOWN;
              end
            end else begin
              addr_d = addr_q + ADDR_ONE;
            end
          end else begin
            // Turning at start+1 so the start endpoint is visited once per pass.
            if (addr_q == start_addr + ADDR_ONE) begin
              addr_d = start_addr;
              dir_d  = DIR_UP;
              loop_d = loop_q + LOOP_ONE;
            end else begin
              addr_d = addr_q - ADDR_ONE;
            end
          end
        end else begin
          dir_d  = DIR_UP;
          tick_d = 1'b1;
          if (addr_q == end_addr) begin
            addr_d = start_addr;
            loop_d = loop_q + LOOP_ONE;
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
        end
      end
    end
  end

  assign beat_addr  = addr_q;
  assign beat_tick  = tick_q;
  assign loop_count = loop_q;
  assign done       = done_q;

endmodule
